// File: rtl/wts_pkg.sv
// Shared constants, frame type and sample conversion for the wave-table
// sound blocks.
package wts_pkg;

   localparam int FRAME_BITS  = 32;
   localparam int SLOT_BITS   = 16;
   localparam int SAMPLE_BITS = 12;
   localparam int SLOT_CNT_W  = $clog2(FRAME_BITS);

   // Word select is high for slots 15..30: one BCLK ahead of the right word.
   localparam int LRCK_HI_FIRST = SLOT_BITS - 1;
   localparam int LRCK_HI_LAST  = FRAME_BITS - 2;

   typedef struct packed {
      logic [SLOT_BITS-1:0] left;
      logic [SLOT_BITS-1:0] right;
   } frame_t;

   // Offset-binary sample to left-justified two's complement.
   function automatic logic [SLOT_BITS-1:0] to_s16(input logic [SAMPLE_BITS-1:0] s,
                                                    input logic                   m);
      if (m) return '0;
      return {~s[SAMPLE_BITS-1], s[SAMPLE_BITS-2:0], {(SLOT_BITS-SAMPLE_BITS){1'b0}}};
   endfunction

endpackage

// File: rtl/wts_i2s_clkgen.sv
// BCLK divider: toggles the bit clock every BCLK_DIV clk cycles and strobes
// fall_en in the terminal-count cycle that is about to drive BCLK low.
module wts_i2s_clkgen #(
   parameter int BCLK_DIV = 6
) (
   input  logic clk,
   input  logic nreset,
   output logic i2s_bclk,
   output logic fall_en
);

   localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

   logic [DIV_W-1:0] r_div;
   logic             r_bclk;
   logic             w_tc;

   assign w_tc = (r_div == DIV_W'(BCLK_DIV - 1));

   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_div  <= '0;
         r_bclk <= 1'b0;
      end else if (w_tc) begin
         r_div  <= '0;
         r_bclk <= ~r_bclk;
      end else begin
         r_div  <= r_div + 1'b1;
      end
   end

   assign i2s_bclk = r_bclk;
   assign fall_en  = w_tc & r_bclk;

endmodule

// File: rtl/wts_i2s_transmitter.sv
// I2S transmitter: captures a stereo 12-bit sample pair once per 32-slot frame
// and shifts it out MSB first as two 16-bit words on the falling BCLK.
module wts_i2s_transmitter
   import wts_pkg::*;
#(
   parameter int BCLK_DIV = 6
) (
   input  logic                   clk,
   input  logic                   nreset,
   input  logic [SAMPLE_BITS-1:0] left_in,
   input  logic [SAMPLE_BITS-1:0] right_in,
   input  logic                   mute,
   output logic                   i2s_bclk,
   output logic                   i2s_lrck,
   output logic                   i2s_sdata,
   output logic                   sample_req
);

   logic                  w_fall_en;
   logic [SLOT_CNT_W-1:0] w_slot_next;
   logic                  w_load;
   logic                  w_lrck_next;
   frame_t                w_frame;

   logic [SLOT_CNT_W-1:0] r_slot;
   logic [FRAME_BITS-1:0] r_shift;
   logic                  r_lrck;
   logic                  r_sdata;
   logic                  r_sample_req;

   wts_i2s_clkgen #(
      .BCLK_DIV (BCLK_DIV)
   ) u_clkgen (
      .clk      (clk),
      .nreset   (nreset),
      .i2s_bclk (i2s_bclk),
      .fall_en  (w_fall_en)
   );

   // NOTE: every combinational output gets a default first, so no path
   // through the block can leave one unassigned and infer a latch.
   always_comb begin
      w_slot_next   = r_slot + 1'b1;
      w_load        = 1'b0;
      w_lrck_next   = 1'b0;
      w_frame.left  = to_s16(left_in, mute);
      w_frame.right = to_s16(right_in, mute);
      if (w_slot_next == '0) w_load = 1'b1;
      if (w_slot_next >= SLOT_CNT_W'(LRCK_HI_FIRST) &&
          w_slot_next <= SLOT_CNT_W'(LRCK_HI_LAST))
         w_lrck_next = 1'b1;
   end

   // Slot counter resets to 31 so the first falling event enters slot 0.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_slot       <= '1;
         r_shift      <= '0;
         r_lrck       <= 1'b0;
         r_sdata      <= 1'b0;
         r_sample_req <= 1'b0;
      end else begin
         r_sample_req <= 1'b0;
         if (w_fall_en) begin
            r_slot <= w_slot_next;
            r_lrck <= w_lrck_next;
            if (w_load) begin
               r_shift      <= w_frame;
               r_sdata      <= w_frame.left[SLOT_BITS-1];
               r_sample_req <= 1'b1;
            end else begin
               r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
               r_sdata <= r_shift[FRAME_BITS-2];
            end
         end
      end
   end

   assign i2s_lrck   = r_lrck;
   assign i2s_sdata  = r_sdata;
   assign sample_req = r_sample_req;

endmodule

// File: tb/tb_wts_i2s_transmitter.sv
// Self-checking bench for wts_i2s_transmitter at BCLK_DIV=6 and BCLK_DIV=2,
// with a cycle-count reference model of the serial waveform.
module tb_wts_i2s_transmitter;

   localparam int DIV_A = 6;
   localparam int DIV_B = 2;

   logic        clk = 1'b0;
   logic        nreset;
   logic [11:0] left_in;
   logic [11:0] right_in;
   logic        mute;

   logic bclk_a, lrck_a, sdata_a, req_a;
   logic bclk_b, lrck_b, sdata_b, req_b;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Reference model state: clk edges since reset release and latest frame.
   int          n_a = 0;
   int          n_b = 0;
   logic [31:0] word_a = '0;
   logic [31:0] word_b = '0;

   always #5 clk = ~clk;

   wts_i2s_transmitter #(.BCLK_DIV(DIV_A)) dut_a (
      .clk        (clk),
      .nreset     (nreset),
      .left_in    (left_in),
      .right_in   (right_in),
      .mute       (mute),
      .i2s_bclk   (bclk_a),
      .i2s_lrck   (lrck_a),
      .i2s_sdata  (sdata_a),
      .sample_req (req_a)
   );

   wts_i2s_transmitter #(.BCLK_DIV(DIV_B)) dut_b (
      .clk        (clk),
      .nreset     (nreset),
      .left_in    (left_in),
      .right_in   (right_in),
      .mute       (mute),
      .i2s_bclk   (bclk_b),
      .i2s_lrck   (lrck_b),
      .i2s_sdata  (sdata_b),
      .sample_req (req_b)
   );

   typedef struct {
      logic [11:0] l;
      logic [11:0] r;
      logic        m;
      logic [15:0] el;
      logic [15:0] er;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Offset binary -> signed value, scaled by 16 into a 16-bit word.
   function automatic logic [15:0] ref_s16(input logic [11:0] s, input logic m);
      int v;
      if (m) return 16'h0000;
      v = (int'(s) - 2048) * 16;
      return v[15:0];
   endfunction

   function automatic bit is_capture(input int n, input int div);
      return (n >= 2 * div) && (((n - 2 * div) % (64 * div)) == 0);
   endfunction

   // Expected {bclk, lrck, sdata, sample_req} after edge n since release.
   function automatic logic [3:0] ref_pins(input int n, input int div, input logic [31:0] word);
      int   f;
      int   slot;
      logic b, l, d, q;
      b    = ((n / div) % 2) == 1;
      f    = n / (2 * div);
      slot = (31 + f) % 32;
      l    = (slot >= 15) && (slot <= 30);
      d    = (f == 0) ? 1'b0 : word[31 - ((f - 1) % 32)];
      q    = is_capture(n, div);
      return {b, l, d, q};
   endfunction

   // Scoreboard: every clk, both DUTs against the model.
   initial begin
      forever begin
         @(posedge clk);
         if (nreset) begin
            n_a++;
            n_b++;
            if (is_capture(n_a, DIV_A)) word_a = {ref_s16(left_in, mute), ref_s16(right_in, mute)};
            if (is_capture(n_b, DIV_B)) word_b = {ref_s16(left_in, mute), ref_s16(right_in, mute)};
         end else begin
            n_a = 0;
            n_b = 0;
         end
         #1;
         check("pins_div6", {28'd0, bclk_a, lrck_a, sdata_a, req_a}, {28'd0, ref_pins(n_a, DIV_A, word_a)});
         check("pins_div2", {28'd0, bclk_b, lrck_b, sdata_b, req_b}, {28'd0, ref_pins(n_b, DIV_B, word_b)});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic wait_req_a(input int limit, output int cycles);
      cycles = 0;
      do begin
         @(posedge clk);
         #1;
         cycles++;
      end while (!req_a && cycles < limit);
      if (!req_a) check("req_timeout", {31'd0, req_a}, 32'd1);
   endtask

   task automatic measure_bclk(input bit use_b, output int period);
      logic prev;
      logic cur;
      int   t0;
      int   cyc;
      t0     = -1;
      cyc    = 0;
      period = 0;
      prev   = use_b ? bclk_b : bclk_a;
      while (cyc < 100 && period == 0) begin
         @(posedge clk);
         #1;
         cyc++;
         cur = use_b ? bclk_b : bclk_a;
         if (cur && !prev) begin
            if (t0 < 0) t0 = cyc;
            else        period = cyc - t0;
         end
         prev = cur;
      end
   endtask

   // Entered just after a capture edge; samples each slot of the DIV_A frame.
   // mode 1 scrambles the data inputs every clk, mode 2 raises mute mid-frame.
   task automatic collect_a(input int mode, output logic [15:0] wl, output logic [15:0] wr);
      logic [31:0] w;
      w = '0;
      for (int b = 0; b < 32; b++) begin
         w[31-b] = sdata_a;
         if (b < 31) begin
            for (int c = 0; c < 2 * DIV_A; c++) begin
               @(negedge clk);
               if (mode == 1) begin
                  left_in  = 12'($urandom);
                  right_in = 12'($urandom);
               end
               if (mode == 2 && b == 8) mute = 1'b1;
               @(posedge clk);
               #1;
            end
         end
      end
      wl = w[31:16];
      wr = w[15:0];
   endtask

   initial begin
      vec_t        vecs[5];
      int          cyc;
      int          per;
      logic [15:0] wl;
      logic [15:0] wr;

      vecs[0] = '{12'hFFF, 12'h000, 1'b0, 16'h7FF0, 16'h8000};
      vecs[1] = '{12'h800, 12'hA5C, 1'b0, 16'h0000, 16'h25C0};
      vecs[2] = '{12'h123, 12'h456, 1'b1, 16'h0000, 16'h0000};
      vecs[3] = '{12'h000, 12'hFFF, 1'b0, 16'h8000, 16'h7FF0};
      vecs[4] = '{12'h7FF, 12'h801, 1'b0, 16'hFFF0, 16'h0010};

      left_in  = 12'h800;
      right_in = 12'h800;
      mute     = 1'b0;
      nreset   = 1'b1;
      #1 nreset = 1'b0;
      #1;
      check("reset_pins_div6", {28'd0, bclk_a, lrck_a, sdata_a, req_a}, 32'd0);
      check("reset_pins_div2", {28'd0, bclk_b, lrck_b, sdata_b, req_b}, 32'd0);
      repeat (3) @(negedge clk);
      nreset = 1'b1;

      wait_req_a(100, cyc);
      check("first_req_clk", cyc, 32'd12);
      wait_req_a(500, cyc);
      check("req_period", cyc, 32'd384);
      measure_bclk(1'b0, per);
      check("bclk_period_div6", per, 32'd12);
      measure_bclk(1'b1, per);
      check("bclk_period_div2", per, 32'd4);

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         left_in  = vecs[i].l;
         right_in = vecs[i].r;
         mute     = vecs[i].m;
         wait_req_a(800, cyc);
         collect_a(1, wl, wr);
         check($sformatf("vec%0d_left", i), {16'd0, wl}, {16'd0, vecs[i].el});
         check($sformatf("vec%0d_right", i), {16'd0, wr}, {16'd0, vecs[i].er});
      end

      @(negedge clk);
      left_in  = 12'hFFF;
      right_in = 12'h000;
      mute     = 1'b0;
      wait_req_a(800, cyc);
      collect_a(2, wl, wr);
      check("mute_mid_left", {16'd0, wl}, 32'h7FF0);
      check("mute_mid_right", {16'd0, wr}, 32'h8000);
      wait_req_a(100, cyc);
      collect_a(0, wl, wr);
      check("mute_next_left", {16'd0, wl}, 32'h0000);
      check("mute_next_right", {16'd0, wr}, 32'h0000);

      repeat (1200) begin
         @(negedge clk);
         left_in  = 12'($urandom);
         right_in = 12'($urandom);
         mute     = ($urandom_range(0, 7) == 0);
      end

      @(negedge clk);
      left_in  = 12'hA5C;
      right_in = 12'h3C1;
      mute     = 1'b0;
      cyc      = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!(n_a >= 12 && ((31 + n_a / 12) % 32) == 20) && cyc < 800);
      @(negedge clk);
      #2 nreset = 1'b0;
      #1;
      check("async_reset_div6", {28'd0, bclk_a, lrck_a, sdata_a, req_a}, 32'd0);
      check("async_reset_div2", {28'd0, bclk_b, lrck_b, sdata_b, req_b}, 32'd0);
      repeat (3) @(negedge clk);
      nreset = 1'b1;
      wait_req_a(100, cyc);
      check("post_reset_first_req", cyc, 32'd12);
      collect_a(0, wl, wr);
      check("post_reset_left", {16'd0, wl}, 32'h25C0);
      check("post_reset_right", {16'd0, wr}, 32'hBC10);
      repeat (20) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
